// File: rtl/tx_data_medipix_pkg.sv
// tx_data_medipix_pkg
// Shared definitions for the Medipix transmit bridge:
//   - state_t : frame sequencer state encoding
//   - M_*     : Medipix mode codes, shared with the receive-side discriminator
//   - frame_takes_bytes() : states in which payload bytes may still be accepted
package tx_data_medipix_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TRAIL = 3'd3,
    ST_END   = 3'd4
  } state_t;

  // Medipix mode codes driven on M alongside the serial frame
  localparam logic [2:0] M_READ_MATRIX = 3'b000;
  localparam logic [2:0] M_LOAD_MATRIX = 3'b001;
  localparam logic [2:0] M_LOAD_DAC    = 3'b010;
  localparam logic [2:0] M_SET_OMR     = 3'b100;
  localparam logic [2:0] M_READ_OMR    = 3'b101;

  // Payload bytes after the sync byte are only taken while the frame is
  // leading in or shifting; IDLE has its own acceptance rules.
  function automatic logic frame_takes_bytes(input state_t s);
    logic r;
    case (s)
      ST_LEAD:  r = 1'b1;
      ST_SHIFT: r = 1'b1;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tx_data_medipix_if.sv
// tx_data_medipix_if
// Byte-source handshake into the Medipix transmit bridge.
//   In_Valid          byte valid
//   In_Sync           first byte of a packet (qualified by In_Valid)
//   In_Data           payload byte, serialised MSB first
//   In_Packet_Length  payload byte count, sampled with the sync byte
//   In_M              Medipix mode, sampled with the sync byte
//   Out_Ready         byte accepted when In_Valid && Out_Ready
// Modports: master = byte source, slave = bridge.
interface tx_data_medipix_if;
  logic        In_Valid;
  logic        In_Sync;
  logic [7:0]  In_Data;
  logic [15:0] In_Packet_Length;
  logic [2:0]  In_M;
  logic        Out_Ready;

  modport master (
    output In_Valid, In_Sync, In_Data, In_Packet_Length, In_M,
    input  Out_Ready
  );

  modport slave (
    input  In_Valid, In_Sync, In_Data, In_Packet_Length, In_M,
    output Out_Ready
  );
endinterface

// File: rtl/tx_data_medipix_mdpx_clk_gen.sv
// mdpx_clk_gen
// Free-running Medipix clock divider. A counter 0..CLK_DIV-1 toggles the
// generated clock at terminal count, giving a period of 2*CLK_DIV clk cycles.
//   clk, rst   system clock, synchronous active-high reset
//   mclk       generated Medipix clock (registered, 0 in reset)
//   fall_tick  high in the clk cycle whose closing edge takes mclk 1->0
//   rise_tick  high in the clk cycle whose closing edge takes mclk 0->1
module mdpx_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic mclk,
  output logic fall_tick,
  output logic rise_tick
);

  localparam logic [15:0] DIV_LAST_C = 16'(CLK_DIV - 1);

  logic [15:0] div_cnt_r;
  logic        mclk_r;
  logic        terminal_s;

  assign terminal_s = (div_cnt_r == DIV_LAST_C);
  assign fall_tick  = terminal_s && mclk_r;
  assign rise_tick  = terminal_s && !mclk_r;
  assign mclk       = mclk_r;

  // divider counter and clock toggle
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r <= 16'd0;
      mclk_r    <= 1'b0;
    end else if (terminal_s) begin
      div_cnt_r <= 16'd0;
      mclk_r    <= ~mclk_r;
    end else begin
      div_cnt_r <= div_cnt_r + 16'd1;
    end
  end

endmodule

// File: rtl/tx_data_medipix.sv
// tx_data_medipix
// Serialises a byte stream onto the Medipix serial data-in line with a
// generated Medipix clock and enable; drives the mode bits M for the frame.
//   In_Clk, In_Reset  sole clock, synchronous active-high reset
//   src               byte-source handshake (tx_data_medipix_if.slave)
//   Out_Clk_Mdpx      generated Medipix clock
//   Out_En_Mdpx       Medipix enable, changes on clock fall only
//   Out_Data_Mdpx     serial data, MSB first, changes on clock fall only
//   Out_M             mode bits latched from the sync byte
//   Out_Busy          frame in progress
//   Out_Done          one-cycle pulse at frame end
//   Out_Err           sticky underrun flag, cleared by the next sync byte
// Build option: define MDPX_TRAILER_EN to append TRAILER_BITS enabled zero
// bits after the payload (flushes the chip's shift register).
module tx_data_medipix
  import tx_data_medipix_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int LEAD_CYCLES  = 8,
  parameter int TRAILER_BITS = 16
) (
  input  logic               In_Clk,
  input  logic               In_Reset,
  tx_data_medipix_if.slave   src,
  output logic               Out_Clk_Mdpx,
  output logic               Out_En_Mdpx,
  output logic               Out_Data_Mdpx,
  output logic [2:0]         Out_M,
  output logic               Out_Busy,
  output logic               Out_Done,
  output logic               Out_Err
);

  localparam logic [15:0] LEAD_LAST_C = 16'(LEAD_CYCLES - 1);
`ifdef MDPX_TRAILER_EN
  localparam logic [15:0] TRAIL_LAST_C = 16'(TRAILER_BITS - 1);
  localparam state_t      TAIL_STATE_C = ST_TRAIL;
`else
  localparam int          unused_trailer_bits_c = TRAILER_BITS;
  localparam state_t      TAIL_STATE_C = ST_END;
`endif

  state_t      state_r, next_state_s;
  logic        fall_tick_s, rise_tick_s, accept_s, tail_s;

  logic [7:0]  hold_r, hold_nxt_s;
  logic        hold_full_r, hold_full_nxt_s;
  logic [7:0]  shift_r, shift_nxt_s;
  logic [2:0]  bit_cnt_r, bit_cnt_nxt_s;
  logic [15:0] len_r, len_nxt_s;
  logic [15:0] acc_cnt_r, acc_cnt_nxt_s;
  logic [15:0] load_cnt_r, load_cnt_nxt_s;
  logic [15:0] lead_cnt_r, lead_cnt_nxt_s;
`ifdef MDPX_TRAILER_EN
  logic [15:0] trail_cnt_r, trail_cnt_nxt_s;
`endif
  logic        en_r, en_nxt_s;
  logic        data_r, data_nxt_s;
  logic [2:0]  m_r, m_nxt_s;
  logic        err_r, err_nxt_s;
  logic        done_r, done_nxt_s;
  logic        ready_r, ready_nxt_s;
  logic        busy_r, busy_nxt_s;

  mdpx_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk       (In_Clk),
    .rst       (In_Reset),
    .mclk      (Out_Clk_Mdpx),
    .fall_tick (fall_tick_s),
    .rise_tick (rise_tick_s)
  );

  assign accept_s      = src.In_Valid && ready_r;
  assign src.Out_Ready = ready_r;
  assign Out_En_Mdpx   = en_r;
  assign Out_Data_Mdpx = data_r;
  assign Out_M         = m_r;
  assign Out_Busy      = busy_r;
  assign Out_Done      = done_r;
  assign Out_Err       = err_r;

  // FSM state register
  always_ff @(posedge In_Clk) begin
    if (In_Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && src.In_Sync && (src.In_Packet_Length != 16'd0)) begin
          next_state_s = ST_LEAD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LEAD: begin
        if (fall_tick_s && (lead_cnt_r == LEAD_LAST_C)) begin
          next_state_s = ST_SHIFT;
        end else begin
          next_state_s = ST_LEAD;
        end
      end
      ST_SHIFT: begin
        // Leave after bit 0 unless a further byte is owed and already held
        if (fall_tick_s && (bit_cnt_r == 3'd0) &&
            !((load_cnt_r != len_r) && hold_full_r)) begin
          next_state_s = TAIL_STATE_C;
        end else begin
          next_state_s = ST_SHIFT;
        end
      end
`ifdef MDPX_TRAILER_EN
      ST_TRAIL: begin
        if (fall_tick_s && (trail_cnt_r == TRAIL_LAST_C)) begin
          next_state_s = ST_END;
        end else begin
          next_state_s = ST_TRAIL;
        end
      end
`endif
      ST_END: begin
        // Enable already dropped; finish once the chip has clocked it in
        if (rise_tick_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_END;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath next values
  always_comb begin
    hold_nxt_s      = hold_r;
    hold_full_nxt_s = hold_full_r;
    shift_nxt_s     = shift_r;
    bit_cnt_nxt_s   = bit_cnt_r;
    len_nxt_s       = len_r;
    acc_cnt_nxt_s   = acc_cnt_r;
    load_cnt_nxt_s  = load_cnt_r;
    lead_cnt_nxt_s  = lead_cnt_r;
`ifdef MDPX_TRAILER_EN
    trail_cnt_nxt_s = trail_cnt_r;
`endif
    en_nxt_s        = en_r;
    data_nxt_s      = data_r;
    m_nxt_s         = m_r;
    err_nxt_s       = err_r;
    done_nxt_s      = 1'b0;
    tail_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && src.In_Sync && (src.In_Packet_Length != 16'd0)) begin
          len_nxt_s       = src.In_Packet_Length;
          m_nxt_s         = src.In_M;
          hold_nxt_s      = src.In_Data;
          hold_full_nxt_s = 1'b1;
          acc_cnt_nxt_s   = 16'd1;
          load_cnt_nxt_s  = 16'd0;
          lead_cnt_nxt_s  = 16'd0;
          err_nxt_s       = 1'b0;
        end else begin
          hold_full_nxt_s = 1'b0;  // non-sync and zero-length bytes are dropped
        end
      end
      ST_LEAD: begin
        if (fall_tick_s && (lead_cnt_r == LEAD_LAST_C)) begin
          shift_nxt_s     = hold_r;
          data_nxt_s      = hold_r[7];
          en_nxt_s        = 1'b1;
          bit_cnt_nxt_s   = 3'd7;
          load_cnt_nxt_s  = load_cnt_r + 16'd1;
          hold_full_nxt_s = 1'b0;
        end else if (fall_tick_s) begin
          lead_cnt_nxt_s = lead_cnt_r + 16'd1;
        end else begin
          lead_cnt_nxt_s = lead_cnt_r;
        end
      end
      ST_SHIFT: begin
        if (fall_tick_s) begin
          if (bit_cnt_r != 3'd0) begin
            // bit on the line always sits in shift_r[7]
            data_nxt_s    = shift_r[6];
            shift_nxt_s   = {shift_r[6:0], 1'b0};
            bit_cnt_nxt_s = bit_cnt_r - 3'd1;
          end else if (load_cnt_r == len_r) begin
            tail_s = 1'b1;
          end else if (hold_full_r) begin
            shift_nxt_s     = hold_r;
            data_nxt_s      = hold_r[7];
            bit_cnt_nxt_s   = 3'd7;
            load_cnt_nxt_s  = load_cnt_r + 16'd1;
            hold_full_nxt_s = 1'b0;
          end else begin
            err_nxt_s = 1'b1;
            tail_s    = 1'b1;
          end
        end else begin
          tail_s = 1'b0;
        end
      end
`ifdef MDPX_TRAILER_EN
      ST_TRAIL: begin
        if (fall_tick_s && (trail_cnt_r == TRAIL_LAST_C)) begin
          en_nxt_s   = 1'b0;
          data_nxt_s = 1'b0;
        end else if (fall_tick_s) begin
          trail_cnt_nxt_s = trail_cnt_r + 16'd1;
        end else begin
          trail_cnt_nxt_s = trail_cnt_r;
        end
      end
`endif
      ST_END: begin
        if (rise_tick_s) begin
          done_nxt_s = 1'b1;
        end else begin
          done_nxt_s = 1'b0;
        end
      end
      default: begin
        done_nxt_s = 1'b0;
      end
    endcase

    // Leaving SHIFT on the fall tick after bit 0
    if (tail_s) begin
`ifdef MDPX_TRAILER_EN
      data_nxt_s      = 1'b0;
      trail_cnt_nxt_s = 16'd0;
`else
      en_nxt_s   = 1'b0;
      data_nxt_s = 1'b0;
`endif
    end else begin
      tail_s = 1'b0;
    end

    // A byte taken in the same cycle as a reload refills the holding register
    if (accept_s && frame_takes_bytes(state_r)) begin
      hold_nxt_s      = src.In_Data;
      hold_full_nxt_s = 1'b1;
      acc_cnt_nxt_s   = acc_cnt_r + 16'd1;
    end else begin
      acc_cnt_nxt_s = acc_cnt_nxt_s;
    end

    // Ready is registered from next-cycle state so it reads 0 in reset
    if (!hold_full_nxt_s && (next_state_s == ST_IDLE)) begin
      ready_nxt_s = 1'b1;
    end else if (!hold_full_nxt_s && frame_takes_bytes(next_state_s) &&
                 (acc_cnt_nxt_s < len_nxt_s)) begin
      ready_nxt_s = 1'b1;
    end else begin
      ready_nxt_s = 1'b0;
    end
    busy_nxt_s = (next_state_s != ST_IDLE);
  end

  // datapath and output registers
  always_ff @(posedge In_Clk) begin
    if (In_Reset) begin
      hold_r      <= 8'd0;
      hold_full_r <= 1'b0;
      shift_r     <= 8'd0;
      bit_cnt_r   <= 3'd0;
      len_r       <= 16'd0;
      acc_cnt_r   <= 16'd0;
      load_cnt_r  <= 16'd0;
      lead_cnt_r  <= 16'd0;
`ifdef MDPX_TRAILER_EN
      trail_cnt_r <= 16'd0;
`endif
      en_r        <= 1'b0;
      data_r      <= 1'b0;
      m_r         <= 3'd0;
      err_r       <= 1'b0;
      done_r      <= 1'b0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      hold_r      <= hold_nxt_s;
      hold_full_r <= hold_full_nxt_s;
      shift_r     <= shift_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      len_r       <= len_nxt_s;
      acc_cnt_r   <= acc_cnt_nxt_s;
      load_cnt_r  <= load_cnt_nxt_s;
      lead_cnt_r  <= lead_cnt_nxt_s;
`ifdef MDPX_TRAILER_EN
      trail_cnt_r <= trail_cnt_nxt_s;
`endif
      en_r        <= en_nxt_s;
      data_r      <= data_nxt_s;
      m_r         <= m_nxt_s;
      err_r       <= err_nxt_s;
      done_r      <= done_nxt_s;
      ready_r     <= ready_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

endmodule
